tx_stream_arbiter: RTL
======================

Name: tx_stream_arbiter

Overview:
- Shares one byte-wide TX sink (the UART TX port or the Ethernet TX FIFO write port) between NUM_REQ byte-stream requesters, e.g. the control bridge and a status/debug message source.
- Grants are frame-atomic: a requester keeps the sink until it transfers a byte flagged last.
- Arbitration between frames is round-robin.
- A stall watchdog reclaims the sink from a requester that goes silent mid-frame.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYC, 4096, consecutive source-stall cycles mid-frame before forced release (>=2).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req_data  in  NUM_REQ*8  requester bytes; requester k occupies bits [8k+7:8k].
- i_req_valid  in  NUM_REQ  requester k has a byte presented.
- i_req_last  in  NUM_REQ  presented byte is the final byte of the frame.
- o_req_ready  out  NUM_REQ  byte of requester k is accepted this cycle.
- o_data  out  8  byte to the sink.
- o_valid  out  1  sink write strobe.
- i_ready  in  1  sink can accept a byte.
- o_grant  out  NUM_REQ  one-hot current owner; zero when idle.
- o_busy  out  1  a frame is in progress.
- o_timeout  out  1  single-cycle pulse on forced release.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE; o_grant=0, o_busy=0, o_timeout=0, o_valid=0, o_req_ready=0, o_data=0; RR pointer=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, ACTIVE.
- IDLE:
  - If any i_req_valid is high, pick the first set bit searching upward from pointer+1 with wrap.
  - Next cycle: o_grant = pick (registered), state ACTIVE. Arbitration latency is 1 cycle.
  - No transfer occurs in IDLE.
- ACTIVE, datapath is combinational pass-through with zero latency and no storage:
  - o_data = i_req_data[g]
  - o_valid = i_req_valid[g]
  - o_req_ready[g] = i_ready
  - Non-granted ready bits are 0.
- Transfer: a cycle with o_valid && i_ready.
- Transfer with i_req_last[g]=1 ends the frame: next cycle IDLE, o_grant=0, pointer=g.
  - The minimum gap between frames is therefore 1 idle cycle.
- A requester re-asserting valid immediately after its last byte loses to any other pending requester.
- Stall counter, width clog2(TIMEOUT_CYC+1):
  - Cleared on every transfer and on entering ACTIVE.
  - Increments in ACTIVE when i_req_valid[g]=0.
  - Holds when the source is valid but i_ready=0; sink backpressure never times out.
- Counter reaching TIMEOUT_CYC:
  - o_timeout pulses 1 cycle.
  - State goes IDLE, pointer=g.
  - The requester's later bytes are arbitrated as a new frame; no byte is dropped or duplicated by the arbiter.
- i_req_last with i_req_valid=0 is ignored.
- last on the first byte (a 1-byte frame) is legal.
- Requester valid low in IDLE: no grant. A single pending requester always wins, whatever the pointer.
- Reset asserted mid-frame: outputs go to reset values immediately and any partial frame is abandoned. The sink-side frame recovery belongs to the consumer.
- o_busy = (state==ACTIVE).
- Exactly one o_grant bit is high in ACTIVE.

Decomposition:
- Shared header holds the state encodings (IDLE/ACTIVE) and the default TIMEOUT_CYC. It is included by this block and by control.
- One sub-module: rr_pick.
  - Combinational round-robin priority encoder.
  - Inputs: request vector and pointer.
  - Outputs: one-hot pick and an any-request flag.
  - Parameterised by NUM_REQ.

Test Plan:
- Single requester:
  - Stimulus: req0 sends 3-byte frame 0xA1,0xA2,0xA3 (last on 0xA3), i_ready=1.
  - Response: o_grant=01 one cycle after valid; o_data sequence A1,A2,A3 on consecutive cycles; IDLE the following cycle.
- Contention after reset:
  - Stimulus: req0 and req1 both valid with 2-byte frames 0x10,0x11 and 0x20,0x21.
  - Response: output 10,11, one idle cycle, then 20,21; req1 ready stays 0 during the req0 frame.
- Round-robin fairness:
  - Stimulus: both requesters continuously send 1-byte frames for 8 frames.
  - Response: grants alternate 0,1,0,1...; each requester gets exactly 4.
- Backpressure:
  - Stimulus: req1 frame 0x55,0x66, i_ready low for 5000 cycles mid-frame.
  - Response: no o_timeout; 0x66 transferred after i_ready returns; o_req_ready[1] mirrors i_ready.
- Watchdog, with TIMEOUT_CYC=16:
  - Stimulus: req0 sends 1 byte without last, then drops valid.
  - Response: o_timeout pulses exactly 16 cycles after the transfer; a pending req1 is granted 1 cycle later.
- Async reset:
  - Stimulus: assert i_rst_n=0 mid-frame between clock edges.
  - Response: o_valid, o_grant and o_req_ready are 0 before the next edge; after release, req0 wins the first contention.

Source files
------------

// File: rtl/tx_stream_arbiter_pkg.sv
// Shared definitions for the TX stream arbiter: FSM encoding and default watchdog depth.
package tx_stream_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT_CYC = 4096;
  localparam int BYTE_W              = 8;

endpackage

// File: rtl/tx_stream_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first request above ptr, with wrap.
module tx_stream_arbiter_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               any
);

  logic found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    any   = |req;
    // i runs 1..NUM_REQ so the pointer's own slot is searched last
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_stream_arbiter.sv
// Frame-atomic round-robin arbiter sharing one byte-wide TX sink between NUM_REQ sources.
// Handshake: a byte moves on any cycle with o_valid && i_ready; o_req_ready[g] is i_ready gated by the grant.
module tx_stream_arbiter
  import tx_stream_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ*BYTE_W-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ-1:0]        i_req_last,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [BYTE_W-1:0]         o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic                      o_busy,
  output logic                      o_timeout
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, pick;
  logic [PTR_W-1:0]   gidx_q, gidx_d, ptr_q, ptr_d, pick_idx;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               timeout_q, timeout_d;
  logic               any_req, active, src_valid, xfer, xfer_last, stall_hit;

  tx_stream_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req  (i_req_valid),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any_req)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = PTR_W'(i);
    end
  end

  assign active    = (state_q == ST_ACTIVE);
  assign src_valid = i_req_valid[gidx_q];
  assign xfer      = active && src_valid && i_ready;
  assign xfer_last = xfer && i_req_last[gidx_q];
  // Fires on the cycle that would bring the count to TIMEOUT_CYC, so the pulse lands in the first idle cycle
  assign stall_hit = active && !src_valid && (stall_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      ptr_q     <= PTR_W'(NUM_REQ - 1);
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      ptr_q     <= ptr_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    stall_d   = stall_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_ACTIVE;
          grant_d = pick;
          gidx_d  = pick_idx;
          stall_d = '0;
        end
      end
      ST_ACTIVE: begin
        if (xfer_last || stall_hit) begin
          state_d   = ST_IDLE;
          grant_d   = '0;
          ptr_d     = gidx_q;
          stall_d   = '0;
          timeout_d = stall_hit;
        end else if (xfer) begin
          stall_d = '0;
        end else if (!src_valid) begin
          stall_d = stall_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_data      = '0;
    o_valid     = 1'b0;
    o_req_ready = '0;
    if (active) begin
      o_data      = i_req_data[int'(gidx_q)*BYTE_W +: BYTE_W];
      o_valid     = src_valid;
      o_req_ready = grant_q & {NUM_REQ{i_ready}};
    end
    o_grant   = grant_q;
    o_busy    = active;
    o_timeout = timeout_q;
  end

endmodule
